// File: rtl/sync_pkg.sv
// ---------------------------------------------------------------------------
// sync_pkg
//   Shared definitions for the request pacer that feeds a pulse-crossing
//   handshake.
//   - pacer_state_e : states of the pacer FSM (also exported on a debug port)
//   - DEF_*         : default parameter values for sync_req_pacer
//   - timer_width() : width of the shared phase/guard timer, large enough to
//                     hold max(TIMEOUT, GAP)
// ---------------------------------------------------------------------------
package sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_WAIT_FALL = 2'd2,
        ST_GUARD     = 2'd3
    } pacer_state_e;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_GAP     = 2;
    localparam int DEF_TIMEOUT = 64;

    // One timer serves both the wait-phase timeout and the guard gap, so it
    // has to hold whichever bound is larger.
    function automatic int timer_width(input int timeout, input int gap);
        int m;
        m = (timeout > gap) ? timeout : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_req_pacer_sat_req_cnt.sv
// ---------------------------------------------------------------------------
// sat_req_cnt
//   Saturating up/down counter holding the number of pending requests.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     inc_i       : add one (a request arrived)
//     dec_i       : subtract one (a request was issued)
//     value_o     : current count
//     sat_hit_o   : combinational pulse when an increment is dropped at max
// ---------------------------------------------------------------------------
module sat_req_cnt
    import sync_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] value_o,
    output logic             sat_hit_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel out. The decrement is only ever
    // requested with a non-zero count, but the floor check keeps the
    // counter from wrapping regardless of the caller.
    always_comb begin
        cnt_d     = cnt_q;
        sat_hit_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) begin
                sat_hit_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/sync_req_pacer.sv
// ---------------------------------------------------------------------------
// sync_req_pacer
//   Source-domain pacer in front of a pulse-crossing handshake. Request
//   pulses are counted as pending and released one at a time as single-cycle
//   start pulses. A new start is only released after the previous crossing
//   has been seen to begin (busy rises) and end (busy falls), followed by a
//   GAP-cycle guard, so back-to-back requests never merge in the crossing.
//
//   Handshake with the crossing: start is a one-cycle pulse issued only
//   while busy is low; the crossing acknowledges by raising busy and
//   completes by dropping it. Each wait phase is bounded by TIMEOUT cycles;
//   an expired phase sets the sticky timeout flag and the issued request is
//   treated as consumed.
//
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     req        : request pulse, one request per high cycle
//     busy       : crossing in-flight level
//     clr        : clears the sticky overflow/timeout flags
//     start      : registered one-cycle start pulse to the crossing
//     pending    : requests counted but not yet issued
//     overflow   : sticky, a request was dropped at saturation
//     timeout    : sticky, a wait phase expired
//     idle       : state is IDLE and nothing is pending
//     state_dbg  : current FSM state for observation
// ---------------------------------------------------------------------------
module sync_req_pacer
    import sync_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP     = DEF_GAP,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             busy,
    input  logic             clr,
    output logic             start,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             timeout,
    output logic             idle,
    output pacer_state_e     state_dbg
);

    localparam int                TMR_W    = timer_width(TIMEOUT, GAP);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = (GAP > 0) ? TMR_W'(GAP - 1) : '0;
    // With no guard gap the wait phases hand straight back to IDLE.
    localparam pacer_state_e      AFTER_WAIT = (GAP > 0) ? ST_GUARD : ST_IDLE;

    pacer_state_e     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             start_q, start_d;
    logic             overflow_q, overflow_d;
    logic             timeout_q, timeout_d;

    logic             issue;
    logic             tmo_set;
    logic             sat_hit;

    sat_req_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (req),
        .dec_i     (issue),
        .value_o   (pending),
        .sat_hit_o (sat_hit)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        start_d = 1'b0;
        issue   = 1'b0;
        tmo_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Never launch while the crossing still reports busy.
                if ((pending != '0) && !busy) begin
                    issue   = 1'b1;
                    start_d = 1'b1;
                    state_d = ST_WAIT_RISE;
                    timer_d = '0;
                end
            end
            ST_WAIT_RISE: begin
                if (busy) begin
                    state_d = ST_WAIT_FALL;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    tmo_set = 1'b1;
                    state_d = AFTER_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_FALL: begin
                if (!busy) begin
                    state_d = AFTER_WAIT;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    tmo_set = 1'b1;
                    state_d = AFTER_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GUARD: begin
                if (timer_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Setting a sticky flag wins over a coincident clear.
        overflow_d = sat_hit | (overflow_q & ~clr);
        timeout_d  = tmo_set | (timeout_q & ~clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            start_q    <= start_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign start     = start_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;
    assign idle      = (state_q == ST_IDLE) && (pending == '0);
    assign state_dbg = state_q;

endmodule

// File: doc/sync_req_pacer.md
Name: sync_req_pacer

Overview:
- Single-clock upstream pacer for the pulse-crossing handshake.
- Collects request pulses in the source clock domain and counts them as pending.
- Issues them one at a time as single-cycle `start` pulses.
- Issues the next `start` only after the in-flight crossing has visibly started and finished (`busy` rise, then fall) plus a guard gap. This keeps back-to-back requests from merging or being lost in the crossing.

Parameters:
- CNT_W, 8: width of the pending-request counter; saturates at 2^CNT_W-1.
- GAP, 2: idle cycles inserted after `busy` falls before the next `start`; 0 allowed.
- TIMEOUT, 64: max cycles spent in each wait phase (busy rise, busy fall) before abort; must be >= 2.

Ports:
- clk, input, 1: source-domain clock; all logic on posedge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, 1: request pulse; each high cycle counts as one request.
- busy, input, 1: level from the crossing's source side; high while a request is in flight.
- clr, input, 1: clears the sticky flags `overflow` and `timeout`.
- start, output, 1: registered one-cycle pulse to the crossing's start input.
- pending, output, CNT_W: requests counted but not yet issued.
- overflow, output, 1: sticky; a request was dropped at saturation.
- timeout, output, 1: sticky; a wait phase exceeded TIMEOUT.
- idle, output, 1: high when state is IDLE and pending == 0.

Behaviour:
- Reset (async assert):
  - state = IDLE; pending = 0; start, overflow, timeout = 0; timer = 0.
  - `idle` = 1 while in reset.
  - Reset asserted mid-operation abandons the in-flight request silently; no `start` is re-issued.
- States: IDLE, WAIT_RISE, WAIT_FALL, GUARD. All outputs are registered except `idle`, which is decoded from registers.
- IDLE:
  - If pending != 0 and busy == 0: start <= 1 for one cycle, pending decrements, go to WAIT_RISE, timer = 0.
  - If busy == 1, stay in IDLE; never issue while busy.
- WAIT_RISE:
  - busy == 1 -> WAIT_FALL, timer = 0.
  - Otherwise timer increments. At timer == TIMEOUT-1 -> timeout <= 1, go to GUARD.
- WAIT_FALL:
  - busy == 0 -> GUARD, timer = 0.
  - Same timeout rule as WAIT_RISE; on expiry go to GUARD.
- GUARD:
  - Counts GAP cycles, then goes to IDLE.
  - With GAP = 0, WAIT_FALL/timeout transitions go directly to IDLE.
- Latency:
  - `req` sampled at edge k with pending = 0, IDLE, busy low -> pending = 1 after edge k.
  - `start` is high for the cycle after edge k+1, and pending returns to 0 at edge k+1.
  - Minimum `start`-to-`start` spacing is 1 + (cycles to busy rise) + (cycles to busy fall) + GAP.
- Counter rules:
  - req and issue in the same cycle: pending unchanged.
  - req at pending == max with no issue: pending holds at max, overflow <= 1.
  - No wrap-around at any time.
- Sticky flags:
  - Set has priority over `clr` in the same cycle.
  - `clr` has no effect on pending or on the state machine.
- Timeout:
  - The issued request is considered consumed (not retried).
  - pending is untouched, and the machine keeps draining normally afterward.
- `req` is accepted in every state.

Decomposition:
- Package sync_pkg:
  - typedef enum for the pacer states (IDLE, WAIT_RISE, WAIT_FALL, GUARD).
  - Timer width derived from TIMEOUT and GAP as a localparam via $clog2(max(TIMEOUT, GAP) + 1).
- Sub-module sat_req_cnt: CNT_W-wide saturating up/down counter.
  - Inputs: inc, dec. Outputs: value, sat_hit (pulse on a dropped increment).
  - The FSM and timer stay in the top module.

Test Plan:
- Reset then single request: pulse req once; bench models busy rising 3 cycles after start and falling 5 cycles later. Expect:
  - exactly one `start` pulse, 2 cycles after req;
  - pending 1->0;
  - idle high again GAP = 2 cycles after busy falls.
- Burst: req high 5 consecutive cycles, same busy model. Expect:
  - pending peaks at 4 (one issued during the burst);
  - 5 `start` pulses total, each separated by >= 1+3+5+2 = 11 cycles;
  - no overflow.
- Saturation: CNT_W = 2, busy held high so nothing issues after the first start, 6 req pulses. Expect:
  - pending stops at 3;
  - overflow = 1;
  - overflow stays 1 until a `clr` pulse, then 0.
- Timeout: busy tied low, one req. Expect:
  - start once;
  - timeout = 1 exactly TIMEOUT cycles after WAIT_RISE entry;
  - return to IDLE after GAP;
  - a second req then issues normally.
- Simultaneous req and issue, plus set/clr collision: req coincident with the issue cycle, pending = 2 -> pending stays 2; clr coinciding with an overflow set -> overflow remains 1.
- Async reset mid-flight: assert reset during WAIT_FALL with pending = 3. Expect:
  - all outputs go to reset values without a clock edge;
  - after release, no `start` occurs without a new req.
